// File: rtl/enc_bundler_if.sv
// Pack-in / query-out bus of the encoder bundler.
// The master side feeds packs and consumes the query; the slave side is the bundler.
interface enc_bundler_if #(
    parameter int HV_DIM    = 1024,
    parameter int PACK_SIZE = 10,
    parameter int IDX_W     = 6
);
    logic              start_bundling;
    logic              in_valid;
    logic              in_ready;
    logic [HV_DIM-1:0] shifted_hv [0:PACK_SIZE-1];
    logic [IDX_W-1:0]  pack_idx;
    logic              busy;
    logic              query_valid;
    logic              query_ready;
    logic [HV_DIM-1:0] query_hv;

    modport master (
        output start_bundling, in_valid, shifted_hv, query_ready,
        input  in_ready, pack_idx, busy, query_valid, query_hv
    );

    modport slave (
        input  start_bundling, in_valid, shifted_hv, query_ready,
        output in_ready, pack_idx, busy, query_valid, query_hv
    );
endinterface

// File: rtl/enc_bundler.sv
// Bundles NUM_PACKS packs of bound hypervectors into per-bit counts, then
// thresholds the counts into one sparse query hypervector.
module enc_bundler #(
    parameter int HV_DIM    = 1024,
    parameter int PACK_SIZE = 10,
    parameter int NUM_PACKS = 40,
    parameter int THRESHOLD = 2,
    parameter int CNT_W     = $clog2(PACK_SIZE*NUM_PACKS+1),
    parameter int IDX_W     = $clog2(NUM_PACKS)
) (
    input logic          clk,
    input logic          nrst,
    enc_bundler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, THRESH, DONE} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  pack_q;
    logic [HV_DIM-1:0] query_q;
    logic [HV_DIM-1:0] thr_hv;
    logic [CNT_W-1:0]  cnt [HV_DIM];
    logic [CNT_W-1:0]  pop [HV_DIM];
    logic              beat;
    logic              last_pack;

    assign last_pack       = (pack_q == IDX_W'(NUM_PACKS-1));
    assign bus.pack_idx    = pack_q;
    assign bus.query_hv    = query_q;
    assign bus.query_valid = (state_q == DONE);
    assign bus.busy        = (state_q == ACCUM) || (state_q == THRESH);

    always_comb begin
        state_d      = state_q;
        bus.in_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_bundling) state_d = ACCUM;
            end
            ACCUM: begin
                bus.in_ready = !bus.start_bundling;
                if (!bus.start_bundling && bus.in_valid && last_pack) state_d = THRESH;
            end
            THRESH: begin
                state_d = bus.start_bundling ? ACCUM : DONE;
            end
            DONE: begin
                if (bus.start_bundling)   state_d = ACCUM;
                else if (bus.query_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        beat = bus.in_valid && bus.in_ready;
    end

    // Per-bit column popcount across the vectors of the current pack.
    always_comb begin
        for (int unsigned b = 0; b < HV_DIM; b++) begin
            pop[b] = '0;
            for (int unsigned p = 0; p < PACK_SIZE; p++) begin
                pop[b] = pop[b] + CNT_W'(bus.shifted_hv[p][b]);
            end
            thr_hv[b] = (cnt[b] >= CNT_W'(THRESHOLD));
        end
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q <= IDLE;
            pack_q  <= '0;
            query_q <= '0;
            for (int unsigned b = 0; b < HV_DIM; b++) cnt[b] <= '0;
        end else begin
            state_q <= state_d;
            if (bus.start_bundling) begin
                pack_q <= '0;
                for (int unsigned b = 0; b < HV_DIM; b++) cnt[b] <= '0;
            end else if (beat) begin
                pack_q <= last_pack ? '0 : pack_q + IDX_W'(1);
                for (int unsigned b = 0; b < HV_DIM; b++) cnt[b] <= cnt[b] + pop[b];
            end
            // An abort while thresholding leaves the previous query in place.
            if (state_q == THRESH && !bus.start_bundling) query_q <= thr_hv;
        end
    end
endmodule

// File: tb/tb_enc_bundler.sv
// Directed-plus-random bench for enc_bundler on a 16-bit, 10x40 configuration,
// checked against per-bit integer counts kept by the bench.
module tb_enc_bundler;
    localparam int HV  = 16;
    localparam int PS  = 10;
    localparam int NP  = 40;
    localparam int THR = 2;

    logic clk = 1'b0;
    logic nrst;
    int   checks = 0;
    int   errors = 0;

    int          mcnt [HV];
    int          mbeats;
    logic [HV-1:0] cur [PS];

    enc_bundler_if #(.HV_DIM(HV), .PACK_SIZE(PS), .IDX_W(6)) bus ();

    enc_bundler #(
        .HV_DIM(HV), .PACK_SIZE(PS), .NUM_PACKS(NP), .THRESHOLD(THR)
    ) dut (
        .clk (clk),
        .nrst(nrst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int b = 0; b < HV; b++) mcnt[b] = 0;
        mbeats = 0;
    endtask

    function automatic logic [HV-1:0] model_query();
        logic [HV-1:0] q;
        for (int b = 0; b < HV; b++) q[b] = (mcnt[b] >= THR);
        return q;
    endfunction

    // mode 0: vector 0 = 0x0003; 1: threshold boundary; 2: all ones; 3: random sparse
    task automatic drive_pack(input int mode, input int beat);
        for (int v = 0; v < PS; v++) begin
            logic [HV-1:0] d;
            case (mode)
                0: d = (v == 0) ? 16'h0003 : 16'h0000;
                1: begin
                    d = 16'h0000;
                    if (beat == 3 && v == 4) d = 16'h0020;
                    if ((beat == 7 && v == 2) || (beat == 20 && v == 9)) d = 16'h0040;
                end
                2: d = 16'hFFFF;
                default: d = HV'($urandom & $urandom & $urandom);
            endcase
            cur[v] = d;
            bus.shifted_hv[v] = d;
        end
    endtask

    task automatic start_pulse(input bit iv);
        bus.start_bundling = 1'b1;
        bus.in_valid = iv;
        drive_pack(2, 0);
        @(negedge clk);
        check("in_ready_on_start", 64'(bus.in_ready), 64'(0));
        @(posedge clk); #1;
        bus.start_bundling = 1'b0;
        bus.in_valid = 1'b0;
        model_clear();
    endtask

    task automatic accum(input int mode, input int n, input bit gaps);
        int got = 0;
        int budget = 0;
        while (got < n && budget < 1000) begin
            budget++;
            bus.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            drive_pack(mode, mbeats);
            @(negedge clk);
            check("in_ready_accum", 64'(bus.in_ready), 64'(1));
            check("pack_idx", 64'(bus.pack_idx), 64'(mbeats));
            check("busy_accum", 64'(bus.busy), 64'(1));
            check("qvalid_accum", 64'(bus.query_valid), 64'(0));
            if (bus.in_valid) begin
                for (int v = 0; v < PS; v++)
                    for (int b = 0; b < HV; b++) mcnt[b] += int'(cur[v][b]);
                mbeats++;
                got++;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        if (got < n) check("accum_budget", 64'(got), 64'(n));
    endtask

    task automatic finish(input int bp, input bit abort);
        logic [HV-1:0] exp = model_query();
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("thresh_qvalid", 64'(bus.query_valid), 64'(0));
        check("thresh_busy", 64'(bus.busy), 64'(1));
        check("thresh_in_ready", 64'(bus.in_ready), 64'(0));
        @(posedge clk); #1;
        for (int k = 0; k < bp; k++) begin
            bus.query_ready = 1'b0;
            @(negedge clk);
            check("done_qvalid", 64'(bus.query_valid), 64'(1));
            check("done_query_hv", 64'(bus.query_hv), 64'(exp));
            check("done_in_ready", 64'(bus.in_ready), 64'(0));
            check("done_busy", 64'(bus.busy), 64'(0));
            @(posedge clk); #1;
        end
        bus.query_ready = 1'b1;
        bus.start_bundling = abort;
        @(negedge clk);
        check("hs_qvalid", 64'(bus.query_valid), 64'(1));
        check("hs_query_hv", 64'(bus.query_hv), 64'(exp));
        check("hs_in_ready", 64'(bus.in_ready), 64'(0));
        @(posedge clk); #1;
        bus.query_ready = 1'b0;
        bus.start_bundling = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("post_qvalid", 64'(bus.query_valid), 64'(0));
        check("post_busy", 64'(bus.busy), 64'(abort));
        check("post_pack_idx", 64'(bus.pack_idx), 64'(0));
        if (!abort) check("post_query_hv", 64'(bus.query_hv), 64'(exp));
        @(posedge clk); #1;
        if (abort) model_clear();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'(0));
        check({tag, "_qvalid"}, 64'(bus.query_valid), 64'(0));
        check({tag, "_query_hv"}, 64'(bus.query_hv), 64'(0));
        check({tag, "_pack_idx"}, 64'(bus.pack_idx), 64'(0));
        check({tag, "_busy"}, 64'(bus.busy), 64'(0));
    endtask

    initial begin
        nrst = 1'b1;
        bus.start_bundling = 1'b0;
        bus.in_valid = 1'b0;
        bus.query_ready = 1'b0;
        for (int v = 0; v < PS; v++) bus.shifted_hv[v] = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        nrst = 1'b0;

        // Idle with in_valid high: nothing may be accepted.
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_pack(2, 0);
            @(negedge clk);
            check_reset_outputs("idle");
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;

        start_pulse(1'b0);
        accum(0, NP, 1'b0);
        finish(1, 1'b0);

        start_pulse(1'b0);
        accum(1, NP, 1'b1);
        finish(0, 1'b0);

        start_pulse(1'b0);
        accum(2, NP, 1'b1);
        finish(20, 1'b0);

        // Reset in the middle of accumulation clears the held all-ones query.
        start_pulse(1'b0);
        accum(3, 10, 1'b0);
        nrst = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        nrst = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        @(posedge clk); #1;
        bus.in_valid = 1'b0;

        // Restart at beat 17 with in_valid high, then discard a finished query.
        start_pulse(1'b0);
        accum(3, 17, 1'b1);
        start_pulse(1'b1);
        accum(3, NP, 1'b1);
        finish(0, 1'b1);
        accum(3, NP, 1'b0);
        finish(2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
